// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//   frame_state_t  : bit-level frame FSM states
//   prefix_state_t : scan-code prefix decoder states
//   PS2_EXT        : extended-key prefix byte (E0)
//   PS2_BREAK      : key-release prefix byte (F0)
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    BASE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } prefix_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronizes the PS/2 pins, detects falling edges of the PS/2 clock,
// deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and abandons a frame when the PS/2 clock stalls.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   ps2_clk     : PS/2 clock pin (asynchronous)
//   ps2_data    : PS/2 data pin (asynchronous)
//   byte_valid  : one-cycle pulse, byte_data holds a good byte
//   byte_data   : received byte
//   frame_err   : one-cycle pulse on parity, stop-bit or timeout error
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          data_s1, data_s2;
  logic          fall;
  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] to_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic          frame_ok;

  assign fall = clk_s3 & ~clk_s2;

  // Good frame: 9 bits with odd parity and a high stop bit.
  assign frame_ok = (^{parity, shift}) & data_s2;

  // Control: synchronizers (reset to bus-idle high), FSM, timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_s3     <= 1'b1;
      data_s1    <= 1'b1;
      data_s2    <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      clk_s3     <= clk_s2;
      data_s1    <= ps2_data;
      data_s2    <= data_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      // Saturating stall counter; only meaningful while a frame is open.
      if (fall || state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt != '1) begin
        to_cnt <= to_cnt + 1'b1;
      end

      // A fall in the same cycle as the timeout still advances the frame.
      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            state <= STOP;
          end
          STOP: begin
            if (frame_ok) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt == TO_LAST) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  // Datapath: shift register, parity capture and byte output (no reset)
  always_ff @(posedge clk) begin
    if (fall && state == DATA) begin
      shift <= {data_s2, shift[7:1]};
    end
    if (fall && state == PARITY) begin
      parity <= data_s2;
    end
    if (fall && state == STOP && frame_ok) begin
      byte_data <= shift;
    end
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard keycode tracker.
// Decodes E0 (extended) and F0 (break) prefixes from received bytes and
// holds the make code of the most recently pressed key until that same
// key is released.
// Ports:
//   Clk, Reset  : system clock, synchronous active-high reset
//   ps2_clk     : PS/2 clock pin (asynchronous)
//   ps2_data    : PS/2 data pin (asynchronous)
//   keycode     : make code of the held key, 8'h00 when none
//   extended    : held keycode was E0-prefixed
//   key_event   : one-cycle pulse per accepted make or break
//   key_release : qualifies key_event, 1 = break, 0 = make
//   frame_err   : one-cycle pulse on a frame error
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       key_event,
  output logic       key_release,
  output logic       frame_err
);

  logic          byte_valid;
  logic [7:0]    byte_data;
  prefix_state_t pst;
  logic          has_ext;
  logic          has_brk;
  logic          is_ext;
  logic          is_brk;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (Clk),
    .rst       (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_comb begin
    has_ext = (pst == GOT_E0) || (pst == GOT_E0F0);
    has_brk = (pst == GOT_F0) || (pst == GOT_E0F0);
    is_ext  = (byte_data == PS2_EXT);
    is_brk  = (byte_data == PS2_BREAK);
  end

  // Prefix decode and output registers, one cycle after byte_valid
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pst         <= BASE;
      keycode     <= 8'h00;
      extended    <= 1'b0;
      key_event   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_event   <= 1'b0;
      key_release <= 1'b0;
      if (frame_err) begin
        pst <= BASE;
      end else if (byte_valid) begin
        if ((is_ext && has_ext) || (is_brk && has_brk)) begin
          // Repeated prefix: swallow it and resynchronize.
          pst <= BASE;
        end else if (is_ext && pst == BASE) begin
          pst <= GOT_E0;
        end else if (is_brk) begin
          // Only reachable from BASE or GOT_E0 here.
          pst <= has_ext ? GOT_E0F0 : GOT_F0;
        end else begin
          pst         <= BASE;
          key_event   <= 1'b1;
          key_release <= has_brk;
          if (!has_brk) begin
            keycode  <= byte_data;
            extended <= has_ext;
          end else if (byte_data == keycode && has_ext == extended) begin
            // Only releasing the held key clears it.
            keycode  <= 8'h00;
            extended <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
module tb_ps2_keycode;

  localparam int TO   = 200;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       extended;
  logic       key_event;
  logic       key_release;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  ps2_keycode #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keycode    (keycode),
    .extended   (extended),
    .key_event  (key_event),
    .key_release(key_release),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts events and errors, flags protocol violations
  int         ev_cnt   = 0;
  int         err_cnt  = 0;
  int         viol_cnt = 0;
  logic       last_rel = 1'b0;
  logic [7:0] prev_kc  = 8'h00;
  logic       prev_ext = 1'b0;
  logic       prev_ev  = 1'b0;
  logic       prev_err = 1'b0;
  logic       rst_d    = 1'b1;

  always @(negedge clk) begin
    if (key_event === 1'b1) begin
      ev_cnt   <= ev_cnt + 1;
      last_rel <= key_release;
    end
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if ((key_event && frame_err) || (key_event && prev_ev) || (frame_err && prev_err))
      viol_cnt <= viol_cnt + 1;
    if (!rst_d && !key_event && (keycode !== prev_kc || extended !== prev_ext))
      viol_cnt <= viol_cnt + 1;
    prev_kc  <= keycode;
    prev_ext <= extended;
    prev_ev  <= key_event;
    prev_err <= frame_err;
    rst_d    <= rst;
  end

  // Reference model: keyboard semantics at the byte level
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  logic [7:0] exp_kc = 8'h00;
  logic       exp_ext = 1'b0;
  int         exp_ev = 0;
  logic       exp_rel = 1'b0;
  int         exp_err = 0;

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hE0 && !m_ext && !m_brk) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1'b1;
    end else if ((b == 8'hE0 && m_ext) || (b == 8'hF0 && m_brk)) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      exp_ev++;
      exp_rel = m_brk;
      if (!m_brk) begin
        exp_kc  = b;
        exp_ext = m_ext;
      end else if (b == exp_kc && m_ext == exp_ext) begin
        exp_kc  = 8'h00;
        exp_ext = 1'b0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic m_error();
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_kc"}, keycode, exp_kc);
    chk({tag, "_ext"}, extended, exp_ext);
    chk({tag, "_ev"}, ev_cnt, exp_ev);
    chk({tag, "_rel"}, last_rel, exp_rel);
    chk({tag, "_err"}, err_cnt, exp_err);
  endtask

  // Drives frame bits first..last (0 = start, 10 = stop)
  task automatic send_bits(input logic [7:0] b, input logic par, input logic stop,
                           input int first, input int last, input bit lat);
    logic [10:0] fr;
    fr = {stop, par, b, 1'b0};
    for (int i = first; i <= last; i++) begin
      ps2_data = fr[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      if (lat && i == 10) begin
        cyc(3);
        chk("lat_n2_event", key_event, 1'b0);
        cyc(1);
        chk("lat_n3_event", key_event, 1'b1);
        chk("lat_n3_kc", keycode, b);
        cyc(HALF - 4);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic good_byte(input logic [7:0] b, input bit lat, input string tag);
    send_bits(b, ~^b, 1'b1, 0, 10, lat);
    m_byte(b);
    cyc(4);
    chk_state(tag);
  endtask

  task automatic bad_byte(input logic [7:0] b, input bit stop_err, input string tag);
    if (stop_err) send_bits(b, ~^b, 1'b0, 0, 10, 1'b0);
    else          send_bits(b, ^b, 1'b1, 0, 10, 1'b0);
    m_error();
    cyc(4);
    chk_state(tag);
  endtask

  logic [7:0] keys [5] = '{8'h1C, 8'h1D, 8'h23, 8'h75, 8'h6B};

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("reset_kc", keycode, 8'h00);
    chk("reset_ext", extended, 1'b0);
    chk("reset_event", key_event, 1'b0);
    chk("reset_release", key_release, 1'b0);
    chk("reset_err", frame_err, 1'b0);

    // Make and break W
    good_byte(8'h1D, 1'b1, "make_w");
    good_byte(8'hF0, 1'b0, "break_prefix");
    good_byte(8'h1D, 1'b0, "break_w");

    // Extended up-arrow, foreign plain break, extended break
    good_byte(8'hE0, 1'b0, "ext_prefix");
    good_byte(8'h75, 1'b0, "make_up");
    good_byte(8'hF0, 1'b0, "plain_f0");
    good_byte(8'h75, 1'b0, "plain_break_75");
    good_byte(8'hE0, 1'b0, "ext_brk_e0");
    good_byte(8'hF0, 1'b0, "ext_brk_f0");
    good_byte(8'h75, 1'b0, "break_up");

    // Overlapping keys
    good_byte(8'h1D, 1'b0, "ovl_make_1d");
    good_byte(8'h1C, 1'b0, "ovl_make_1c");
    good_byte(8'hF0, 1'b0, "ovl_f0_a");
    good_byte(8'h1D, 1'b0, "ovl_break_1d");
    good_byte(8'hF0, 1'b0, "ovl_f0_b");
    good_byte(8'h1C, 1'b0, "ovl_break_1c");

    // Typematic repeat, parity and stop errors
    good_byte(8'h1D, 1'b0, "repeat_a");
    good_byte(8'h1D, 1'b0, "repeat_b");
    bad_byte(8'h1D, 1'b0, "parity_err");
    bad_byte(8'h23, 1'b1, "stop_err");

    // Timeout after start + 4 data bits, then recovery
    send_bits(8'h1D, 1'b1, 1'b1, 0, 4, 1'b0);
    cyc(TO + 20);
    m_error();
    chk_state("timeout");
    good_byte(8'h1C, 1'b0, "after_timeout");

    // Reset mid-frame while 1D is held
    good_byte(8'h1D, 1'b0, "pre_reset");
    send_bits(8'h1D, 1'b1, 1'b1, 0, 4, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_kc", keycode, 8'h00);
    chk("midrst_ext", extended, 1'b0);
    chk("midrst_event", key_event, 1'b0);
    chk("midrst_release", key_release, 1'b0);
    chk("midrst_err", frame_err, 1'b0);
    exp_kc  = 8'h00;
    exp_ext = 1'b0;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    // Leftover bits 1,0,0,0,1,1 open a bogus frame (start at the first 0)
    // holding only four data bits, so it ends in a timeout error.
    send_bits(8'h1D, 1'b1, 1'b1, 5, 10, 1'b0);
    cyc(TO + 20);
    m_error();
    chk_state("midrst_tail");
    good_byte(8'h1C, 1'b0, "after_reset");

    // Randomized key traffic with occasional corrupted frames
    for (int it = 0; it < 40; it++) begin
      logic [7:0] k;
      bit         e;
      bit         brk;
      k   = keys[$urandom_range(0, 4)];
      e   = 1'($urandom_range(0, 1));
      brk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        bad_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rnd_bad");
      if (e)   good_byte(8'hE0, 1'b0, "rnd_e0");
      if (brk) good_byte(8'hF0, 1'b0, "rnd_f0");
      good_byte(k, 1'b0, "rnd_code");
    end

    cyc(4);
    chk("pulse_rules", viol_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keycode.md
# ps2_keycode

PS/2 keyboard receiver that produces the 8-bit `keycode` consumed by the player-motion logic. It deserializes 11-bit PS/2 device-to-host frames, decodes the E0 (extended) and F0 (break) prefixes, and holds the most recently pressed make code until that key is released. It sits between the board's PS/2 pins and every module that reads `keycode`.

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of `Clk` cycles without a PS/2 clock fall, while a frame is in progress, before the frame is abandoned (1 ms at 50 MHz).
- `Clk` in 1: system clock; all state is updated on its rising edge.
- `Reset` in 1: one clock; reset is synchronous and active-high.
- `ps2_clk` in 1: PS/2 clock from the pin; asynchronous to `Clk`.
- `ps2_data` in 1: PS/2 data from the pin; asynchronous to `Clk`.
- `keycode` out 8: make code of the held key; 8'h00 when no key is held.
- `extended` out 1: `keycode` was prefixed by E0.
- `key_event` out 1: one-cycle pulse for each accepted make or break.
- `key_release` out 1: qualifies `key_event`; 1 = break, 0 = make.
- `frame_err` out 1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Synchronizer: `ps2_clk` and `ps2_data` each pass through 2 flops (s1, s2). A third flop s3 delays clk s2. fall = s3 & ~s2. Data is taken from data s2 in the fall cycle.
- Frame FSM, with actions only on fall:
  - IDLE: data 0 -> DATA with bit count 0. Data 1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first. After 8 bits -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: the frame is good when the 9 bits (8 data + parity) have odd parity and the stop bit is 1. Good frame -> byte_valid pulse with the byte. Otherwise -> frame_err pulse. Both cases -> IDLE.
- Timeout: the counter clears on every fall and whenever the FSM is in IDLE. If the FSM is not in IDLE and the counter reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, frame_err pulses and the partial byte is discarded.
- Prefix decoder states: BASE, GOT_E0, GOT_F0, GOT_E0F0.
  - E0 in BASE -> GOT_E0.
  - F0 in BASE -> GOT_F0.
  - F0 in GOT_E0 -> GOT_E0F0.
  - Any other byte completes a code and the decoder returns to BASE.
  - On any frame error the decoder returns to BASE.
- Make code c with ext flag e:
  - `keycode` <= c, `extended` <= e.
  - `key_event` = 1, `key_release` = 0.
  - Typematic repeats of the same make code re-pulse `key_event`.
- Break code c with ext flag e:
  - `key_event` = 1, `key_release` = 1 in every case.
  - If c == `keycode` and e == `extended`: `keycode` <= 0 and `extended` <= 0.
  - Otherwise `keycode` and `extended` are unchanged, because the released key was not the held one.
- A byte E0 or F0 received in a state that already holds that prefix is treated as a completed code byte: the decoder returns to BASE and the outputs do not change.

## Timing
- Reset values: `keycode` = 0, `extended` = 0, `key_event` = 0, `key_release` = 0, `frame_err` = 0. FSMs reset to IDLE and BASE. Counters reset to 0. All synchronizer flops reset to 1 (the bus idle level).
- Reset mid-frame: all of the above apply on the next edge, and the partial frame is lost.
- Latency: if the stop-bit `ps2_clk` low level is first captured by s1 at edge N, then:
  - fall is asserted in the cycle after edge N+1.
  - byte_valid is registered at edge N+2.
  - `keycode`, `extended`, `key_event` and `key_release` update at edge N+3.
  - `frame_err` for a parity or stop-bit error is registered at edge N+2.
- `key_event` and `frame_err` are never asserted together.
- Every pulse lasts exactly 1 `Clk` cycle.
- `keycode` and `extended` change only in the cycle in which `key_event` is 1.
- The timeout counter has ceil(log2(TIMEOUT_CYCLES)) bits and saturates; it cannot wrap.

## Structure
- Package `ps2_pkg`:
  - enum `frame_state_t` {IDLE, DATA, PARITY, STOP}.
  - enum `prefix_state_t` {BASE, GOT_E0, GOT_F0, GOT_E0F0}.
  - constants `PS2_EXT` = 8'hE0 and `PS2_BREAK` = 8'hF0.
- Sub-module `ps2_frame_rx`: synchronizers, fall detect, frame FSM and timeout. Its outputs are `byte_valid`, `byte_data[7:0]` and `frame_err`.
- `ps2_keycode` contains the prefix decoder and the output registers.

## Test plan
- Make W: frame 8'h1D with parity 1 -> `keycode` = 8'h1D, `extended` = 0, `key_event` pulses once with `key_release` = 0, at edge N+3.
- Break W: send F0, 1D after the make -> `keycode` = 8'h00 and `key_event` pulses with `key_release` = 1. The F0 byte alone produces no `key_event`.
- Extended up-arrow: send E0, 75 -> `keycode` = 8'h75, `extended` = 1. Then send E0, F0, 75 -> `keycode` = 0, `extended` = 0. Also send a plain F0, 75 while E0 75 is held -> `keycode` stays 8'h75.
- Overlapping keys: make 1D, make 1C, then F0 1D -> `keycode` stays 8'h1C and `key_release` pulses. Then F0 1C -> `keycode` = 0.
- Errors:
  - 8'h1D sent with parity 0 -> `frame_err` pulses and `keycode` is unchanged.
  - A frame with stop bit 0 -> `frame_err`.
  - 5 bits sent, then the clock held idle for TIMEOUT_CYCLES -> `frame_err`, after which a following valid 8'h1C is accepted.
- Reset mid-frame: assert `Reset` for 1 cycle after 4 data bits while 8'h1D is held -> all outputs are 0 on the next edge. The remaining bits of that frame cause no `key_event`, and the next complete frame is decoded normally.
